// File: rtl/sound_out_fifo.sv
// ---------------------------------------------------------------------------
// sound_out_fifo
//   Sample buffer that sits directly in front of the I2S sender. It stores
//   32-bit stereo words (L in [31:16], R in [15:0]) and primes itself before
//   it issues the start pulse to the sender. After that it hands over one word
//   for each request tick from the sender. When a tick finds the buffer empty,
//   the sender receives silence and a sticky underrun flag is set.
//
// Ports
//   in_clk        sole clock, all logic on the rising edge
//   reset         synchronous, active-high
//   enable        stream enable from sound-out control
//   wr_valid      write strobe from upstream
//   wr_data       32-bit sample word
//   wr_ready      combinational: accepting writes (not idle, not full)
//   sample_tick   one-cycle word request from the sender
//   out_valid     one-cycle strobe to the sender, one per tick in RUN
//   out_data      word for the sender, held between strobes
//   start_pulse   one-cycle start pulse to the sender
//   fill_req      registered refill request (level below LOW_WATER)
//   level         current occupancy, 0..2^DEPTH_LOG2
//   underrun      sticky flag, set when a tick finds the buffer empty
//   underrun_clr  clears underrun (a set in the same cycle takes priority)
// ---------------------------------------------------------------------------
module sound_out_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LOW_WATER  = 4
) (
    input  logic                  in_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    input  logic [31:0]           wr_data,
    output logic                  wr_ready,
    input  logic                  sample_tick,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic                  start_pulse,
    output logic                  fill_req,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] LOW_L   = LOW_WATER[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [DEPTH_LOG2-1:0]   wptr_reg;
    logic [DEPTH_LOG2-1:0]   rptr_reg;
    logic [DEPTH_LOG2:0]     level_reg;
    logic                    out_valid_reg;
    logic [31:0]             out_data_reg;
    logic                    start_pulse_reg;
    logic                    fill_req_reg;
    logic                    underrun_reg;

    logic [31:0] mem [DEPTH];

    logic push;
    logic pop;
    logic tick_run;
    logic empty_tick;

    // wr_ready uses the pre-pop level. A full buffer therefore refuses a
    // write even in the cycle in which a word is popped.
    always_comb begin
        wr_ready   = (state_reg != ST_IDLE) && (level_reg < DEPTH_L);
        push       = wr_valid && wr_ready;
        tick_run   = (state_reg == ST_RUN) && sample_tick;
        pop        = tick_run && (level_reg != '0);
        empty_tick = tick_run && (level_reg == '0);
    end

    // Storage has no reset so that it maps onto block RAM.
    always_ff @(posedge in_clk) begin
        if (push) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            wptr_reg        <= '0;
            rptr_reg        <= '0;
            level_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            start_pulse_reg <= 1'b0;
            fill_req_reg    <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            start_pulse_reg <= 1'b0;
            fill_req_reg    <= (state_reg != ST_IDLE) && (level_reg < LOW_L);

            // Every tick in RUN yields a strobe. This includes a tick in the
            // cycle that enable drops. An empty buffer yields silence.
            out_valid_reg <= tick_run;
            if (tick_run) begin
                out_data_reg <= pop ? mem[rptr_reg] : 32'h0;
            end

            if (empty_tick) begin
                underrun_reg <= 1'b1;
            end else if (underrun_clr) begin
                underrun_reg <= 1'b0;
            end

            if (state_reg == ST_IDLE || !enable) begin
                // Idle, or leaving PRIME/RUN: keep the buffer flushed.
                wptr_reg  <= '0;
                rptr_reg  <= '0;
                level_reg <= '0;
                state_reg <= (state_reg == ST_IDLE && enable) ? ST_PRIME : ST_IDLE;
            end else begin
                if (push) begin
                    wptr_reg <= wptr_reg + 1'b1;
                end
                if (pop) begin
                    rptr_reg <= rptr_reg + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   level_reg <= level_reg + 1'b1;
                    2'b01:   level_reg <= level_reg - 1'b1;
                    default: level_reg <= level_reg;
                endcase
                // Priming is judged on the registered level, so the start
                // pulse follows the edge after the threshold write.
                if (state_reg == ST_PRIME && level_reg >= LOW_L) begin
                    start_pulse_reg <= 1'b1;
                    state_reg       <= ST_RUN;
                end
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign start_pulse = start_pulse_reg;
    assign fill_req    = fill_req_reg;
    assign level       = level_reg;
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_sound_out_fifo.sv
module tb_sound_out_fifo;

    logic        in_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        sample_tick;
    logic        out_valid;
    logic [31:0] out_data;
    logic        start_pulse;
    logic        fill_req;
    logic [4:0]  level;
    logic        underrun;
    logic        underrun_clr;

    sound_out_fifo #(.DEPTH_LOG2(4), .LOW_WATER(4)) dut (
        .in_clk       (in_clk),
        .reset        (reset),
        .enable       (enable),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .sample_tick  (sample_tick),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .start_pulse  (start_pulse),
        .fill_req     (fill_req),
        .level        (level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 in_clk = ~in_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sp_cnt = 0;

    logic [31:0] exp_q[$];   // scoreboard: words the sender should receive
    logic [31:0] m_q[$];     // bench model of buffer contents
    int          m_state = 0; // 0 idle, 1 prime, 2 run

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: compares every strobe against the scoreboard, counts start pulses.
    initial begin
        forever begin
            @(negedge in_clk);
            if (start_pulse === 1'b1) sp_cnt++;
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_word: got %h expected no strobe", out_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL out_word: got %h expected %h", out_data, e);
                    end else begin
                        $display("ok   out_word: %h", out_data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // One clock cycle of stimulus. The model predicts the outcome from its
    // own pre-edge state.
    task automatic step(input logic wv, input logic [31:0] wd, input logic tk, input logic clr);
        int  pre_size;
        logic acc;
        wr_valid     = wv;
        wr_data      = wd;
        sample_tick  = tk;
        underrun_clr = clr;
        pre_size = m_q.size();
        acc = wv && (m_state != 0) && (pre_size < 16);
        if (m_state == 2 && tk) begin
            if (pre_size > 0) exp_q.push_back(m_q.pop_front());
            else              exp_q.push_back(32'h0);
        end
        if (m_state != 0 && !enable) begin
            m_q.delete();
            m_state = 0;
        end else begin
            if (acc) m_q.push_back(wd);
            if (m_state == 0 && enable) m_state = 1;
            else if (m_state == 1 && pre_size >= 4) m_state = 2;
        end
        @(posedge in_clk);
        #1;
        wr_valid     = 1'b0;
        sample_tick  = 1'b0;
        underrun_clr = 1'b0;
    endtask

    int sp0;

    initial begin
        reset = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = '0;
        sample_tick = 1'b0; underrun_clr = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        reset = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_start", 32'(start_pulse), 32'd0);
        chk("rst_fill_req", 32'(fill_req), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Priming: three writes give no start, the fourth one triggers it.
        enable = 1'b1;
        step(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);   // dropped: still idle
        chk("idle_drop_level", 32'(level), 32'd0);
        sp0 = sp_cnt;
        step(1'b1, 32'hA000_0001, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0002, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0003, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("prime3_no_start", 32'(sp_cnt - sp0), 32'd0);
        chk("prime3_fill_req", 32'(fill_req), 32'd1);
        step(1'b1, 32'hD000_0004, 1'b0, 1'b0);
        chk("prime4_level", 32'(level), 32'd4);
        chk("prime4_fill_req_lag", 32'(fill_req), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("prime4_start_now", 32'(start_pulse), 32'd1);
        chk("prime4_fill_req", 32'(fill_req), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("start_once", 32'(sp_cnt - sp0), 32'd1);

        // Ticks: back-to-back, gap, then one more. Each yields a strobe one cycle later.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("tick1_valid", 32'(out_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("tick2_valid", 32'(out_valid), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("gap_valid", 32'(out_valid), 32'd0);
        repeat (7) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("tick3_data", out_data, 32'hC000_0003);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_level", 32'(level), 32'd0);

        // Underrun: silence, sticky flag, set wins over clear.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ur_data", out_data, 32'h0);
        chk("ur_set", 32'(underrun), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("ur_set_beats_clr", 32'(underrun), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("ur_clr", 32'(underrun), 32'd0);

        // Full buffer, pop-with-write refusal, wrap-around traffic.
        for (int i = 0; i < 16; i++) step(1'b1, 32'h1600_0000 + 32'(i), 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
        chk("full_pop_drop_level", 32'(level), 32'd15);
        step(1'b1, 32'h1700_0000, 1'b0, 1'b0);
        chk("refill_level", 32'(level), 32'd16);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b1, 1'b0);
        chk("wrap_level", 32'(level), 32'd15);
        repeat (15) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_drain_level", 32'(level), 32'd0);
        chk("ur_after_wrap", 32'(underrun), 32'd0);

        // Disable with level 7, which flushes the buffer. Ticks are ignored while idle.
        for (int i = 0; i < 7; i++) step(1'b1, 32'h7700_0000 + 32'(i), 1'b0, 1'b0);
        chk("pre_dis_level", 32'(level), 32'd7);
        enable = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("dis_level", 32'(level), 32'd0);
        chk("dis_wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 32'hDEAD_0001, 1'b1, 1'b0);
        chk("idle_tick_valid", 32'(out_valid), 32'd0);
        chk("idle_write_level", 32'(level), 32'd0);
        enable = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        sp0 = sp_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h8800_0000 + 32'(i), 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("reprime_start_once", 32'(sp_cnt - sp0), 32'd1);

        // Reset mid-stream with level 9 and underrun set.
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ur_again", 32'(underrun), 32'd1);
        for (int i = 0; i < 9; i++) step(1'b1, 32'h9900_0000 + 32'(i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd9);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        sample_tick = 1'b1;
        @(posedge in_clk);
        #1;
        reset = 1'b0;
        sample_tick = 1'b0;
        m_q.delete();
        m_state = 0;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_fill_req", 32'(fill_req), 32'd0);
        chk("mid_rst_start", 32'(start_pulse), 32'd0);
        @(negedge in_clk);
        @(negedge in_clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_out_fifo.md
# sound_out_fifo

Sound-out sample buffer directly upstream of the I2S sender, in the `in_clk` domain. Accepts 32-bit stereo sample words (L in [31:16], R in [15:0]) from the NeXT sound-out data path and stores them in a small FIFO. Primes the FIFO before issuing the sender's start pulse, then delivers one word per sender request tick. Substitutes silence and flags underrun when the FIFO is empty.

## Interface
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 words (16).
- `LOW_WATER`, 4, priming threshold and refill-request threshold; 1 ≤ LOW_WATER ≤ 2^DEPTH_LOG2.
- `in_clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  stream enable from sound-out control.
- `wr_valid`  in  1  write strobe from upstream.
- `wr_data`  in  32  sample word to write.
- `wr_ready`  out  1  combinational; 1 when state≠IDLE and level < depth.
- `sample_tick`  in  1  one-cycle request from the sender (its `audio_req_tick`).
- `out_valid`  out  1  one-cycle strobe to the sender's `in_valid`.
- `out_data`  out  32  word to the sender's `in_data`; held between strobes.
- `start_pulse`  out  1  one-cycle pulse to the sender's `audio_start_in`.
- `fill_req`  out  1  registered; 1 in PRIME/RUN while level < LOW_WATER.
- `level`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `underrun`  out  1  sticky underrun flag.
- `underrun_clr`  in  1  clears `underrun`.

## Operation
- Storage: 2^DEPTH_LOG2 × 32 array with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth. A separate level counter is the only full/empty source.
- Push: wr_valid && wr_ready. Writes at wptr, wptr+1, level+1. Writes with wr_ready=0 are dropped silently.
- Pop: only in RUN on sample_tick with level>0. Reads at rptr, rptr+1, level−1.
- Simultaneous push and pop: level unchanged, both pointers advance. wr_ready uses the pre-pop level, so a full FIFO does not accept a write in the cycle it is popped.
- Pop request with level=0 and a simultaneous push: the push is stored, no bypass, and the tick is an underrun.
- States:
  - IDLE: FIFO flushed (pointers and level 0), wr_ready=0, ticks ignored. enable=1 → PRIME.
  - PRIME: writes accepted, ticks ignored. When level ≥ LOW_WATER (evaluated on the registered level): assert start_pulse for one cycle, → RUN.
  - RUN: every sample_tick produces exactly one out_valid. If level>0, out_data = head word. If level=0, out_data = 32'h0 and underrun is set.
  - enable=0 in PRIME or RUN → IDLE next cycle, with flush. A pending out_valid from the previous cycle's tick still completes.
- underrun: set on an empty-FIFO tick in RUN. Cleared by underrun_clr. Set wins over clear in the same cycle. Persists across IDLE until cleared.
- out_data is not cleared on flush. It changes only with out_valid.

## Timing
- Reset: state IDLE; level 0; pointers 0; out_valid 0; out_data 0; start_pulse 0; fill_req 0; underrun 0; wr_ready 0.
- Tick latency: sample_tick high at edge n → out_valid high during cycle n+1 for exactly one cycle, with out_data valid in the same cycle. Back-to-back ticks give back-to-back strobes.
- start_pulse: high for the one cycle after the edge at which registered level first reaches LOW_WATER in PRIME. Issued at most once per IDLE→PRIME entry.
- A write at edge n is visible in level after edge n and is poppable by a tick sampled at edge n+1.
- fill_req updates one cycle after level changes.
- reset mid-operation overrides everything at that edge. A tick on the reset edge is lost.

## Test plan
- Reset, enable=1, write 3 words → no start_pulse, fill_req=1. Write a 4th word → start_pulse for one cycle; level=4; fill_req drops one cycle later.
- In RUN with words A,B,C queued, ticks at cycles 10, 11, 20 → out_valid at 11, 12, 21 with A, B, C; level ends at 0.
- Empty FIFO in RUN, tick → out_valid with out_data=0, underrun=1. underrun_clr together with another empty tick → underrun stays 1. Clear alone → 0.
- Fill to 16 → wr_ready=0, level=16. Tick plus wr_valid in the same cycle → write dropped, level=15. Next write accepted. Write 40 words through with ticks to check pointer wrap and data order.
- enable dropped in RUN with level=7 → IDLE next cycle, level=0, wr_ready=0, ticks ignored. Re-enable → PRIME again and a fresh start_pulse after 4 writes.
- Assert reset mid-stream with level=9 and underrun=1 → all outputs at reset values next cycle.
